// File: rtl/multi_btn_debouncer.sv
// Multi-channel button debouncer: 2-flop sync, stability counter, press/release pulses, press counter.
// Define LONG_PRESS_EN to add per-channel hold timers, long_pulse and long-press release suppression.
module multi_btn_debouncer #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned DEB_CYCLES  = 65536,
  parameter int unsigned PRESS_MAX   = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned LONG_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_BTN-1:0]       btn_in,
  input  logic [N_BTN-1:0]       count_clr,
  output logic [N_BTN-1:0]       btn_out,
  output logic [N_BTN-1:0]       press_pulse,
  output logic [N_BTN-1:0]       release_pulse,
  output logic [N_BTN-1:0]       long_pulse,
  output logic [N_BTN*CNT_W-1:0] count_out,
  output logic                   any_active
);

  localparam int unsigned      DW       = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESS_MAX);

  logic [N_BTN-1:0] sync1, sync2, btn_d;
  logic [N_BTN-1:0] long_hit, rel_evt;
  logic [DW-1:0]    stab [N_BTN];
  logic [CNT_W-1:0] cnt  [N_BTN];

  // btn_d lags btn_out by one cycle, so edges are seen (and pulsed) the cycle after btn_out moves.
  always_comb begin
    rel_evt = btn_d & ~btn_out & ~long_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      btn_out       <= '0;
      btn_d         <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        stab[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      sync1         <= btn_in;
      sync2         <= sync1;
      btn_d         <= btn_out;
      press_pulse   <= btn_out & ~btn_d;
      release_pulse <= rel_evt;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync2[i] == btn_out[i]) begin
          stab[i] <= '0;
        end else if (stab[i] == DEB_LAST) begin
          stab[i]    <= '0;
          btn_out[i] <= ~btn_out[i];
        end else begin
          stab[i] <= stab[i] + 1'b1;
        end

        if (count_clr[i]) begin
          cnt[i] <= '0;
        end else if (rel_evt[i]) begin
          cnt[i] <= (cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned   HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold [N_BTN];

  // Timer parks at LONG_CYCLES: gives one long_pulse per hold and flags the release to skip.
  always_ff @(posedge clk) begin
    if (reset) begin
      long_pulse <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        long_pulse[i] <= btn_out[i] && (hold[i] == HOLD_LAST);
        if (!btn_out[i]) begin
          hold[i] <= '0;
        end else if (hold[i] != HOLD_SAT) begin
          hold[i] <= hold[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    long_hit = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      long_hit[i] = (hold[i] == HOLD_SAT);
    end
  end
`else
  assign long_pulse = '0;
  assign long_hit   = '0;
`endif

  always_comb begin
    count_out = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      count_out[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  assign any_active = |btn_out;

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Scoreboard bench for multi_btn_debouncer: stimulus pushes expected output events, a monitor pops and compares.
module tb_multi_btn_debouncer;

  localparam int unsigned NB = 4, DEB = 16, PMAX = 8, CW = 4, LONGC = 64;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] count_clr = '0;
  logic [NB-1:0] btn_out, press_pulse, release_pulse, long_pulse;
  logic [NB*CW-1:0] count_out;
  logic          any_active;

  multi_btn_debouncer #(
    .N_BTN      (NB),
    .DEB_CYCLES (DEB),
    .PRESS_MAX  (PMAX),
    .CNT_W      (CW),
    .LONG_CYCLES(LONGC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .count_clr    (count_clr),
    .btn_out      (btn_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .count_out    (count_out),
    .any_active   (any_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [NB-1:0] btn, prs, rel, lng;
    logic [NB*CW-1:0] cnt;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  logic [NB-1:0] exp_btn = '0;
  int unsigned   exp_cnt [NB] = '{0, 0, 0, 0};
  logic [NB-1:0]    prev_btn = '0;
  logic [NB*CW-1:0] prev_cnt = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, expv);
  endfunction

  function automatic logic [NB*CW-1:0] pack_cnt();
    logic [NB*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*CW +: CW] = CW'(exp_cnt[i]);
    return r;
  endfunction

  function automatic void push(int at, logic [NB-1:0] prs, logic [NB-1:0] rel, logic [NB-1:0] lng);
    ev_t e;
    e.cyc = at; e.btn = exp_btn; e.prs = prs; e.rel = rel; e.lng = lng; e.cnt = pack_cnt();
    q.push_back(e);
  endfunction

  // Monitor: any pulse, level change or count change is an output event to match.
  initial forever begin
    @(posedge clk);
    #2;
    if (mon_en && !reset &&
        (((press_pulse | release_pulse | long_pulse) != '0) ||
         (btn_out !== prev_btn) || (count_out !== prev_cnt))) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event@%0d: got btn=%b prs=%b rel=%b lng=%b cnt=%h, expected no event",
                 cyc, btn_out, press_pulse, release_pulse, long_pulse, count_out);
      end else begin
        mon_e = q.pop_front();
        chk($sformatf("event@%0d(cyc,btn,prs,rel,lng,cnt,any)", mon_e.cyc),
            {16'(cyc), btn_out, press_pulse, release_pulse, long_pulse, count_out, 7'd0, any_active},
            {16'(mon_e.cyc), mon_e.btn, mon_e.prs, mon_e.rel, mon_e.lng, mon_e.cnt, 7'd0, |mon_e.btn});
      end
    end
    prev_btn = btn_out;
    prev_cnt = count_out;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_btn_out"}, 64'(btn_out), 64'(0));
    chk({tag, "_press"}, 64'(press_pulse), 64'(0));
    chk({tag, "_release"}, 64'(release_pulse), 64'(0));
    chk({tag, "_long"}, 64'(long_pulse), 64'(0));
    chk({tag, "_count"}, 64'(count_out), 64'(0));
    chk({tag, "_any"}, 64'(any_active), 64'(0));
  endtask

  task automatic press_start(logic [NB-1:0] m, bit lng_exp);
    int t = cyc;
    btn_in  = btn_in | m;
    exp_btn = exp_btn | m;
    push(t + 18, '0, '0, '0);
    push(t + 19, m, '0, '0);
    if (lng_exp) push(t + 82, '0, '0, m);
  endtask

  task automatic release_part(logic [NB-1:0] m, int lo, bit clr, bit lng_hit);
    int t = cyc;
    btn_in  = btn_in & ~m;
    exp_btn = exp_btn & ~m;
    push(t + 18, '0, '0, '0);
    if (!lng_hit) begin
      for (int i = 0; i < NB; i++)
        if (m[i]) exp_cnt[i] = clr ? 0 : ((exp_cnt[i] == PMAX) ? 0 : exp_cnt[i] + 1);
      push(t + 19, '0, m, '0);
    end
    tick(18);
    if (clr) count_clr = m;
    tick(1);
    count_clr = '0;
    tick(lo - 19);
  endtask

  task automatic press_release(logic [NB-1:0] m, int hi, int lo, bit clr, bit lng);
    press_start(m, lng);
    tick(hi);
    release_part(m, lo, clr, lng);
  endtask

  initial begin
    tick(3);
    reset_checks("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Clean step on channel 0: level at +18, press pulse at +19, counted release.
    press_release(4'b0001, 30, 30, 1'b0, 1'b0);

    // Glitches of 10 and 15 cycles are rejected; 16 cycles is accepted.
    btn_in[1] = 1'b1; tick(10); btn_in[1] = 1'b0; tick(40);
    btn_in[1] = 1'b1; tick(15); btn_in[1] = 1'b0; tick(40);
    chk("glitch_btn_out", 64'(btn_out), 64'(exp_btn));
    chk("glitch_count", 64'(count_out), 64'(pack_cnt()));
    press_start(4'b0010, 1'b0);
    tick(16);
    release_part(4'b0010, 30, 1'b0, 1'b0);

    // Nine presses on channel 2: count 1..8 then wraps to 0.
    for (int k = 0; k < 9; k++) press_release(4'b0100, 30, 30, 1'b0, 1'b0);

    // Lone clear on channel 0.
    count_clr = 4'b0001;
    exp_cnt[0] = 0;
    push(cyc + 1, '0, '0, '0);
    tick(1);
    count_clr = '0;
    tick(3);

    // Channel 3 to count 5, then clear coincident with the next counted release.
    for (int k = 0; k < 5; k++) press_release(4'b1000, 20, 20, 1'b0, 1'b0);
    press_release(4'b1000, 20, 25, 1'b1, 1'b0);

    // 100-cycle hold on channel 0.
    press_release(4'b0001, 100, 30, 1'b0, LONG_EN);

    // Simultaneous press/release on channels 0 and 3.
    press_release(4'b1001, 30, 30, 1'b0, 1'b0);

    // Reset one cycle mid-debounce with channel 1 held through it.
    btn_in[1] = 1'b1;
    tick(12);
    mon_en = 1'b0;
    reset  = 1'b1;
    tick(1);
    reset_checks("midreset");
    reset   = 1'b0;
    exp_btn = '0;
    for (int i = 0; i < NB; i++) exp_cnt[i] = 0;
    mon_en  = 1'b1;
    press_start(4'b0010, 1'b0);
    tick(30);
    release_part(4'b0010, 30, 1'b0, 1'b0);

    tick(5);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
